gpio_serial_writer: RTL and testbench
=====================================

# gpio_serial_writer

Fabric-side transmitter for the GPIO serial configuration protocol consumed by `dac_driver`. It accepts one command at a time, each a target register plus a 256-bit value, over a valid/ready handshake. It then drives `gpio_ctrl` and `select_out` with the same bit-serial framing the host uses: `sdata` plus one per-target serial clock. It sits between on-chip control logic (sequencers, calibration FSMs) and one or more `dac_driver` instances, so configuration no longer requires the PS GPIO path.

## Interface
- `GPIO_WIDTH`, 16, width of `gpio_ctrl`.
- `DATA_WIDTH`, 256, bits shifted for word targets.
- `SETUP_CYCLES`, 2, cycles `sdata` is stable before the strobe rises; minimum 1.
- `HIGH_CYCLES`, 2, cycles the strobe is high; minimum 1.
- `HOLD_CYCLES`, 2, cycles after the strobe falls before the next bit; minimum 1.
- `FLAG_PULSES`, 8, strobe count for flag targets.

- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `s_cmd_target` in 3: `gpio_target_t` code.
- `s_cmd_data` in `DATA_WIDTH`: value to send.
- `s_cmd_valid` in 1: command present.
- `s_cmd_ready` out 1: writer idle and able to accept.
- `gpio_ctrl` out `GPIO_WIDTH`: `sdata` bit plus all serial-clock bits; other bits are always 0.
- `select_out` out 1: frame qualifier to the driver's `select_in`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at end of every frame.
- `err` out 1: one-cycle pulse when a reserved target is dropped.

## Operation
- States: IDLE, SETUP, HIGH, HOLD, FINISH.
- Targets and their types:
  - Word targets shift `DATA_WIDTH` bits, LSB first: CYCLE_COUNT, MASK, LOCKING_WAVEFORM, PRE_DELAY, POST_DELAY.
  - Flag targets hold `sdata = s_cmd_data[0]` for all `FLAG_PULSES` strobes: MUX_SET, MASK_ENABLE.
  - Code 7 is reserved.
- IDLE:
  - `s_cmd_ready=1`.
  - On `s_cmd_valid && s_cmd_ready`, latch target and data, clear the bit counter, and go to SETUP.
  - A reserved target goes to FINISH instead, with `err` pulsed in that FINISH cycle and `done` also pulsed.
- SETUP: drive `sdata` = current bit; strobe low; run `SETUP_CYCLES` cycles; then go to HIGH.
- HIGH: assert the target's strobe bit in `gpio_ctrl`; `sdata` unchanged; run `HIGH_CYCLES` cycles; then go to HOLD.
- HOLD: strobe low; `sdata` unchanged; run `HOLD_CYCLES` cycles. At the end:
  - If bits or pulses remain, increment the counter and return to SETUP.
  - Otherwise go to FINISH.
- FINISH: one cycle with `select_out=0`, `gpio_ctrl=0`, `done=1`; then go to IDLE.
- Output levels during a frame:
  - `select_out=1` and `busy=1` in SETUP, HIGH and HOLD.
  - At most one strobe bit is ever high, and never in the same cycle that `sdata` changes.
- Bit counter: 9 bits wide, compared against `DATA_WIDTH-1` or `FLAG_PULSES-1`; it never wraps.
- Input data changes during a frame are ignored; only the latched copy is used.

## Timing
- Reset values: `gpio_ctrl=0`, `select_out=0`, `busy=0`, `done=0`, `err=0`, `s_cmd_ready=1`, state IDLE.
- All outputs are registered.
- Reset mid-frame: all outputs reach their reset values on the cycle after `rst` is sampled, and the frame is abandoned. The driver sees a truncated shift and must be rewritten.
- Let P = `SETUP_CYCLES+HIGH_CYCLES+HOLD_CYCLES`. With the handshake at edge T:
  - `select_out` rises after edge T.
  - The first strobe rises `SETUP_CYCLES` cycles later.
  - `done` is high in cycle T+1+N·P, where N = 256 for word targets and 8 for flag targets.
  - `s_cmd_ready` returns the following cycle.
  - Defaults give 1538 cycles per word frame and 50 per flag frame.
- A reserved target gives `done` and `err` at T+1 and `s_cmd_ready` at T+2.
- Back-to-back commands are separated by at least one FINISH cycle with `select_out=0`.

## Configuration
- `GPIO_WRITER_SHADOW_EN` defined:
  - Adds ports `rd_target` (in, 3) and `rd_data` (out, `DATA_WIDTH`).
  - Keeps a shadow register per target, updated in FINISH of each completed frame. Flag targets store the bit zero-extended; reserved and reset-aborted frames do not update.
  - `rd_data` is registered, with 1-cycle latency from `rd_target`.
  - Shadows reset to 0.
- Undefined: no shadow storage and no read ports.

## Structure
- Package `rfsoc_config` holds:
  - `gpio_target_t`, a 3-bit enum.
  - The existing bit-index constants (`sdata`, `cycle_count_clk`, `mask_clk`, `pre_delay_cycle_clk`, `post_delay_cycle_clk`, `locking_waveform_clk`, `mux_set_clk`, `mask_enable_clk`).
  - A function mapping target to strobe bit index and to word/flag type.
- Sub-module `gpio_strobe_timer` owns the SETUP/HIGH/HOLD phase counter. It takes a `start` input and provides `phase` and `bit_done` outputs.

## Test plan
- Word frame: CYCLE_COUNT, data 10 -> 256 `cycle_count_clk` pulses; `sdata` reads 0,1,0,1 on pulses 0-3 and 0 thereafter; `done` 1537 cycles after accept; a loopback `dac_driver` reports cycle count 10.
- Flag frame: MUX_SET, data 1 -> 8 `mux_set_clk` pulses with `sdata=1`; `done` at accept+49; `s_cmd_ready` at accept+50.
- Back-to-back: MASK `{8{16'h0000},8{16'hFFFF}}`, then MASK_ENABLE 1, both with `valid` held high -> a 1-cycle `select_out` low gap between frames; the driver's mask and mask enable match.
- Reserved target 7 -> no strobe activity; `err` and `done` at accept+1; `s_cmd_ready` at accept+2.
- Reset at bit 100 of a LOCKING_WAVEFORM frame -> all outputs 0 the next cycle; a new command is accepted in the following cycle; with `GPIO_WRITER_SHADOW_EN` defined, the shadow is unchanged.
- With `GPIO_WRITER_SHADOW_EN`: write PRE_DELAY 2, then set `rd_target` = PRE_DELAY -> `rd_data` = 2 one cycle later.

Source files
------------

// File: rtl/gpio_serial_writer_pkg.sv
// gpio_serial_writer_pkg: target codes, GPIO bit map and target decode for the serial config writer
// Package rfsoc_config: gpio_target_t codes, strobe phase type, gpio_ctrl bit
// indices and the target -> (strobe bit, word/flag) mapping.
package rfsoc_config;
   typedef enum logic [2:0] {
      CYCLE_COUNT      = 3'd0,
      MASK             = 3'd1,
      PRE_DELAY        = 3'd2,
      POST_DELAY       = 3'd3,
      LOCKING_WAVEFORM = 3'd4,
      MUX_SET          = 3'd5,
      MASK_ENABLE      = 3'd6,
      RESERVED         = 3'd7
   } gpio_target_t;
   typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HIGH, P_HOLD} strobe_phase_t;
   localparam int sdata                = 0;
   localparam int cycle_count_clk      = 1;
   localparam int mask_clk             = 2;
   localparam int pre_delay_cycle_clk  = 3;
   localparam int post_delay_cycle_clk = 4;
   localparam int locking_waveform_clk = 5;
   localparam int mux_set_clk          = 6;
   localparam int mask_enable_clk      = 7;
   typedef struct packed {
      logic       flag;
      logic [3:0] idx;
   } target_info_t;
   function automatic target_info_t target_info(input gpio_target_t t);
      target_info_t r;
      r.flag = t == MUX_SET || t == MASK_ENABLE;
      r.idx  = t == CYCLE_COUNT      ? 4'(cycle_count_clk) :
               t == MASK             ? 4'(mask_clk) :
               t == PRE_DELAY        ? 4'(pre_delay_cycle_clk) :
               t == POST_DELAY       ? 4'(post_delay_cycle_clk) :
               t == LOCKING_WAVEFORM ? 4'(locking_waveform_clk) :
               t == MUX_SET          ? 4'(mux_set_clk) :
               t == MASK_ENABLE      ? 4'(mask_enable_clk) : 4'(sdata);
      return r;
   endfunction
   function automatic logic target_reserved(input gpio_target_t t);
      return t == RESERVED;
   endfunction
endpackage

// File: rtl/gpio_serial_writer_strobe_timer.sv
// gpio_strobe_timer: SETUP/HIGH/HOLD phase sequencer for one serial bit
// Ports: start restarts a bit at SETUP; phase is the current phase,
// phase_last flags the final cycle of that phase, bit_done the final HOLD cycle.
import rfsoc_config::*;
module gpio_strobe_timer #(
   parameter int SETUP_CYCLES = 2,
   parameter int HIGH_CYCLES  = 2,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output strobe_phase_t phase,
   output logic          phase_last,
   output logic          bit_done
);
   logic [15:0] cnt;
   always_comb begin
      phase_last = phase == P_SETUP ? cnt == 16'(SETUP_CYCLES - 1) :
                   phase == P_HIGH  ? cnt == 16'(HIGH_CYCLES - 1) :
                   phase == P_HOLD  ? cnt == 16'(HOLD_CYCLES - 1) : 1'b0;
      bit_done   = phase == P_HOLD && phase_last;
   end
   always_ff @(posedge clk)
      if (rst) begin
         phase <= P_IDLE;
         cnt   <= '0;
      end else if (start) begin
         phase <= P_SETUP;
         cnt   <= '0;
      end else if (phase != P_IDLE) begin
         cnt <= phase_last ? '0 : cnt + 16'd1;
         if (phase_last)
            phase <= phase == P_SETUP ? P_HIGH : phase == P_HIGH ? P_HOLD : P_IDLE;
      end
endmodule

// File: rtl/gpio_serial_writer.sv
// gpio_serial_writer: bit-serial GPIO configuration transmitter for dac_driver
// Ports: s_cmd_* valid/ready command (target + DATA_WIDTH value); gpio_ctrl carries
// sdata and the per-target strobes; select_out frames the shift; busy/done/err status.
// GPIO_WRITER_SHADOW_EN adds per-target shadow registers read via rd_target/rd_data.
import rfsoc_config::*;
module gpio_serial_writer #(
   parameter int GPIO_WIDTH   = 16,
   parameter int DATA_WIDTH   = 256,
   parameter int SETUP_CYCLES = 2,
   parameter int HIGH_CYCLES  = 2,
   parameter int HOLD_CYCLES  = 2,
   parameter int FLAG_PULSES  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            s_cmd_target,
   input  logic [DATA_WIDTH-1:0] s_cmd_data,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   output logic [GPIO_WIDTH-1:0] gpio_ctrl,
   output logic                  select_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
`ifdef GPIO_WRITER_SHADOW_EN
   ,
   input  logic [2:0]            rd_target,
   output logic [DATA_WIDTH-1:0] rd_data
`endif
);
   typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, FINISH} state_t;
   state_t                state;
   gpio_target_t          tgt;
   logic [DATA_WIDTH-1:0] data_q;
   logic [8:0]            cnt;
   target_info_t          cur;
   strobe_phase_t         phase;
   logic                  phase_last, bit_done, accept, acc_res, last_bit, start, nxt_bit;
   logic [GPIO_WIDTH-1:0] strobe;
   always_comb begin
      cur      = target_info(tgt);
      acc_res  = target_reserved(gpio_target_t'(s_cmd_target));
      accept   = state == IDLE && s_cmd_valid && s_cmd_ready;
      last_bit = cnt == (cur.flag ? 9'(FLAG_PULSES - 1) : 9'(DATA_WIDTH - 1));
      start    = (accept && !acc_res) || (state == HOLD && bit_done && !last_bit);
      nxt_bit  = cur.flag ? data_q[0] : 1'(data_q >> (cnt + 9'd1));
      strobe   = GPIO_WIDTH'(1) << cur.idx;
   end
   gpio_strobe_timer #(
      .SETUP_CYCLES(SETUP_CYCLES),
      .HIGH_CYCLES (HIGH_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .phase     (phase),
      .phase_last(phase_last),
      .bit_done  (bit_done)
   );
   // Outputs are loaded on the same edge as the state they belong to, so
   // every pin comes straight from a flop.
   always_ff @(posedge clk)
      if (rst) begin
         state       <= IDLE;
         tgt         <= CYCLE_COUNT;
         data_q      <= '0;
         cnt         <= '0;
         s_cmd_ready <= 1'b1;
         gpio_ctrl   <= '0;
         select_out  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else case (state)
         IDLE: if (accept) begin
            tgt         <= gpio_target_t'(s_cmd_target);
            data_q      <= s_cmd_data;
            cnt         <= '0;
            s_cmd_ready <= 1'b0;
            state       <= acc_res ? FINISH : SETUP;
            select_out  <= !acc_res;
            busy        <= !acc_res;
            gpio_ctrl   <= acc_res ? '0 : GPIO_WIDTH'(s_cmd_data[0]) << sdata;
            done        <= acc_res;
            err         <= acc_res;
         end
         SETUP: if (phase == P_SETUP && phase_last) begin
            state     <= HIGH;
            gpio_ctrl <= gpio_ctrl | strobe;
         end
         HIGH: if (phase == P_HIGH && phase_last) begin
            state     <= HOLD;
            gpio_ctrl <= gpio_ctrl & ~strobe;
         end
         HOLD: if (bit_done) begin
            state      <= last_bit ? FINISH : SETUP;
            cnt        <= last_bit ? cnt : cnt + 9'd1;
            gpio_ctrl  <= last_bit ? '0 : GPIO_WIDTH'(nxt_bit) << sdata;
            select_out <= !last_bit;
            busy       <= !last_bit;
            done       <= last_bit;
         end
         default: begin
            state       <= IDLE;
            s_cmd_ready <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
         end
      endcase
`ifdef GPIO_WRITER_SHADOW_EN
   logic [DATA_WIDTH-1:0] shadow [8];
   // err is only high in the FINISH of a dropped reserved command.
   always_ff @(posedge clk)
      if (rst) begin
         for (int i = 0; i < 8; i++) shadow[i] <= '0;
         rd_data <= '0;
      end else begin
         if (state == FINISH && !err) shadow[tgt] <= cur.flag ? DATA_WIDTH'(data_q[0]) : data_q;
         rd_data <= shadow[rd_target];
      end
`endif
endmodule

// File: tb/tb_gpio_serial_writer.sv
// tb_gpio_serial_writer: scoreboard bench for gpio_serial_writer
module tb_gpio_serial_writer;
   localparam int NP_W = 256 * 6;
   localparam int NP_F = 8 * 6;
   logic         clk = 0, rst = 1;
   logic [2:0]   s_cmd_target = 0;
   logic [255:0] s_cmd_data = '0;
   logic         s_cmd_valid = 0;
   logic         s_cmd_ready;
   logic [15:0]  gpio_ctrl;
   logic         select_out, busy, done, err;
`ifdef GPIO_WRITER_SHADOW_EN
   logic [2:0]   rd_target = 0;
   logic [255:0] rd_data;
`endif
   int n_checks = 0, n_fail = 0, cyc = 0, pulses = 0;
   int sb[$];
   int strobe_of[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
   logic [15:0] prev_strb = 0;
   logic        prev_sdata = 0;

   gpio_serial_writer dut (
      .clk(clk), .rst(rst), .s_cmd_target(s_cmd_target), .s_cmd_data(s_cmd_data),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .gpio_ctrl(gpio_ctrl),
      .select_out(select_out), .busy(busy), .done(done), .err(err)
`ifdef GPIO_WRITER_SHADOW_EN
      , .rd_target(rd_target), .rd_data(rd_data)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [15:0] strb, exp_strb;
      int e;
      strb = gpio_ctrl & 16'hFFFE;
      if (strb != 0 && prev_strb == 0) begin
         pulses++;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got gpio_ctrl=%h, required no strobe", gpio_ctrl);
         end else begin
            e = sb.pop_front();
            exp_strb = 16'd1 << (e >> 1);
            if (strb !== exp_strb || gpio_ctrl[0] !== e[0]) begin
               n_fail++;
               $display("FAIL strobe_bit: pulse %0d got strobe=%h sdata=%b, required strobe=%h sdata=%b",
                        pulses, strb, gpio_ctrl[0], exp_strb, e[0]);
            end
         end
      end
      if (strb != 0 && prev_strb != 0) begin
         n_checks++;
         if (gpio_ctrl[0] !== prev_sdata || strb !== prev_strb) begin
            n_fail++;
            $display("FAIL strobe_stable: got gpio_ctrl=%h, required strobe=%h sdata=%b held",
                     gpio_ctrl, prev_strb, prev_sdata);
         end
      end
      if (select_out === 1'b0) begin
         n_checks++;
         if (gpio_ctrl !== 16'h0) begin
            n_fail++;
            $display("FAIL idle_gpio: got gpio_ctrl=%h with select_out=0, required 0000", gpio_ctrl);
         end
      end
      prev_strb  <= strb;
      prev_sdata <= gpio_ctrl[0];
   end

   task automatic push_frame(input logic [2:0] t, input logic [255:0] d);
      int n = (t == 3'd5 || t == 3'd6) ? 8 : 256;
      for (int i = 0; i < n; i++) sb.push_back(strobe_of[t] * 2 + int'(n == 8 ? d[0] : d[i]));
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic send(input logic [2:0] t, input logic [255:0] d, input bit hold, output int acc);
      s_cmd_target = t;
      s_cmd_data   = d;
      s_cmd_valid  = 1;
      for (int i = 0; i < 4000 && s_cmd_ready !== 1'b1; i++) @(negedge clk);
      if (s_cmd_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got s_cmd_ready=%b, required 1", s_cmd_ready);
      end
      if (t != 3'd7) push_frame(t, d);
      @(negedge clk);
      acc = cyc;
      if (!hold) begin
         s_cmd_valid = 0;
         s_cmd_data  = {8{32'hDEADBEEF}};
      end
   endtask

   task automatic wait_done(input string name, input int acc, input int lat, input logic exp_err);
      int seen = -1;
      for (int i = 0; i <= lat + 10; i++) begin
         if (done === 1'b1) begin
            seen = cyc - acc;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (seen != lat) begin
         n_fail++;
         $display("FAIL %s_done_latency: got %0d, required %0d", name, seen, lat);
      end
      n_checks++;
      if (err !== exp_err || select_out !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_finish: got err=%b select=%b busy=%b, required err=%b select=0 busy=0",
                  name, err, select_out, busy, exp_err);
      end
      @(negedge clk);
      n_checks++;
      if (s_cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || select_out !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready: got ready=%b done=%b err=%b select=%b, required 1 0 0 0",
                  name, s_cmd_ready, done, err, select_out);
      end
   endtask

   task automatic check_sb_empty(input string name);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_pulse_count: got %0d pulses outstanding, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({s_cmd_ready, select_out, busy, done, err} !== 5'b10000 || gpio_ctrl !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_values: got ready=%b select=%b busy=%b done=%b err=%b gpio=%h, required 1 0 0 0 0 0000",
                  s_cmd_ready, select_out, busy, done, err, gpio_ctrl);
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_word();
      int acc, p0 = pulses;
      send(3'd0, 256'd10, 0, acc);
      n_checks++;
      if ({select_out, busy, s_cmd_ready} !== 3'b110 || gpio_ctrl !== 16'h0000) begin
         n_fail++;
         $display("FAIL word_start: got select=%b busy=%b ready=%b gpio=%h, required 1 1 0 0000",
                  select_out, busy, s_cmd_ready, gpio_ctrl);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (gpio_ctrl !== 16'h0002) begin
         n_fail++;
         $display("FAIL word_first_strobe: got gpio=%h, required 0002", gpio_ctrl);
      end
      wait_done("word", acc, NP_W, 1'b0);
      check_sb_empty("word");
      n_checks++;
      if (pulses - p0 != 256) begin
         n_fail++;
         $display("FAIL word_pulses: got %0d, required 256", pulses - p0);
      end
   endtask

   task automatic test_flag();
      int acc;
      send(3'd5, 256'd1, 0, acc);
      n_checks++;
      if (gpio_ctrl !== 16'h0001) begin
         n_fail++;
         $display("FAIL flag_sdata: got gpio=%h, required 0001", gpio_ctrl);
      end
      wait_done("flag", acc, NP_F, 1'b0);
      check_sb_empty("flag");
   endtask

   task automatic test_back_to_back();
      int a1, a2;
      send(3'd1, {{8{16'h0000}}, {8{16'hFFFF}}}, 1, a1);
      s_cmd_target = 3'd6;
      s_cmd_data   = 256'd1;
      wait_done("b2b_mask", a1, NP_W, 1'b0);
      send(3'd6, 256'd1, 0, a2);
      n_checks++;
      if (a2 - a1 != NP_W + 2 || select_out !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: got accept spacing %0d select=%b, required %0d select=1",
                  a2 - a1, select_out, NP_W + 2);
      end
      wait_done("b2b_en", a2, NP_F, 1'b0);
      check_sb_empty("b2b");
   endtask

   task automatic test_reserved();
      int acc, p0 = pulses;
      send(3'd7, {8{$urandom}}, 0, acc);
      wait_done("reserved", acc, 0, 1'b1);
      n_checks++;
      if (pulses != p0) begin
         n_fail++;
         $display("FAIL reserved_strobes: got %0d pulses, required 0", pulses - p0);
      end
   endtask

   task automatic test_reset_midframe();
      int acc, acc2, c0, p0 = pulses;
      send(3'd4, {8{$urandom}}, 0, acc);
      for (int i = 0; i < 1000 && pulses - p0 < 100; i++) @(negedge clk);
      rst = 1;
      @(negedge clk);
      n_checks++;
      if ({s_cmd_ready, select_out, busy, done, err} !== 5'b10000 || gpio_ctrl !== 16'h0) begin
         n_fail++;
         $display("FAIL midframe_reset: got ready=%b select=%b busy=%b done=%b err=%b gpio=%h, required 1 0 0 0 0 0000",
                  s_cmd_ready, select_out, busy, done, err, gpio_ctrl);
      end
      rst = 0;
      sb.delete();
      c0 = cyc;
      send(3'd6, 256'd0, 0, acc2);
      n_checks++;
      if (acc2 != c0 + 1) begin
         n_fail++;
         $display("FAIL post_reset_accept: got edge %0d, required %0d", acc2, c0 + 1);
      end
      wait_done("post_reset", acc2, NP_F, 1'b0);
      check_sb_empty("post_reset");
   endtask

`ifdef GPIO_WRITER_SHADOW_EN
   task automatic test_shadow();
      int acc;
      rd_target = 3'd4;
      @(negedge clk);
      n_checks++;
      if (rd_data !== 256'd0) begin
         n_fail++;
         $display("FAIL shadow_aborted: got %h, required 0", rd_data);
      end
      send(3'd2, 256'd2, 0, acc);
      wait_done("shadow", acc, NP_W, 1'b0);
      check_sb_empty("shadow");
      rd_target = 3'd2;
      @(negedge clk);
      n_checks++;
      if (rd_data !== 256'd2) begin
         n_fail++;
         $display("FAIL shadow_read: got %h, required 2", rd_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_word();
      test_flag();
      test_back_to_back();
      test_reserved();
      test_reset_midframe();
`ifdef GPIO_WRITER_SHADOW_EN
      test_shadow();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
